pq_share_ctrl: RTL and testbench

//  Front-end controller that shares one shift-register priority queue (pq_if-style enq/deq/kvi/kvo/empty/full)

---
 rtl/pq_share_ctrl.sv | 147 ++++++++++++++
 tb/tb_pq_share_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/pq_share_ctrl.sv
// rtl/pq_share_ctrl.sv - round-robin enqueue / registered-pop front end sharing one priority queue
// Optional PQ_SHARE_STATS_EN adds saturating enqueue/dequeue/stall counters.
module pq_share_ctrl #(
  parameter int NREQ      = 4,
  parameter int KEY_WIDTH = 8,
  parameter int VAL_WIDTH = 8,
  localparam int KW       = KEY_WIDTH + VAL_WIDTH,
  localparam int PW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*KW-1:0] req_kv,
  output logic [NREQ-1:0]    req_ready,
  input  logic               deq_req,
  output logic               out_valid,
  output logic [KW-1:0]      out_kv,
  input  logic               out_ready,
  input  logic               flush,
  output logic               busy,
  output logic               pq_rst,
  output logic               pq_enq,
  output logic               pq_deq,
  output logic [KW-1:0]      pq_kvi,
  input  logic [KW-1:0]      pq_kvo,
  input  logic               pq_empty,
`ifdef PQ_SHARE_STATS_EN
  output logic [31:0]        stat_enq_cnt,
  output logic [31:0]        stat_deq_cnt,
  output logic [31:0]        stat_stall_cnt,
`endif
  input  logic               pq_full
);

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [KW-1:0]   out_kv_q, out_kv_d;
  logic            pend_q, pend_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [KW-1:0]   kvi_hold_q, kvi_hold_d;

  logic            run, slot_free, enq_ok, gnt_found;
  logic [PW-1:0]   gnt_idx, scan_idx;
  logic [KW-1:0]   gnt_kv;
  int              scan;

  // Combinational outputs are masked during rst so nothing transfers before the registers settle.
  assign run       = (state_q == ST_RUN) && !rst;
  assign slot_free = !out_valid_q || out_ready;
  assign pq_deq    = run && (pend_q || deq_req) && !pq_empty && slot_free;
  assign enq_ok    = run && (!pq_full || pq_deq);
  assign pq_enq    = enq_ok && gnt_found;
  assign pq_kvi    = pq_enq ? gnt_kv : kvi_hold_q;
  assign req_ready = pq_enq ? (NREQ'(1) << gnt_idx) : '0;
  assign pq_rst    = rst || (state_q == ST_FLUSH);
  assign busy      = !rst && ((state_q == ST_FLUSH) || pend_q);
  assign out_valid = out_valid_q;
  assign out_kv    = out_kv_q;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = 0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan = int'(rr_ptr_q) + k;
      if (scan >= NREQ) scan = scan - NREQ;
      scan_idx = PW'(scan);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
    gnt_kv = req_kv[int'(gnt_idx)*KW +: KW];
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_kv_d    = out_kv_q;
    pend_d      = pend_q;
    rr_ptr_d    = rr_ptr_q;
    kvi_hold_d  = kvi_hold_q;
    if (state_q == ST_FLUSH) begin
      state_d     = ST_RUN;
      out_valid_d = 1'b0;
      pend_d      = 1'b0;
    end else begin
      if (flush) state_d = ST_FLUSH;
      if (pq_deq) begin
        out_kv_d    = pq_kvo;
        out_valid_d = 1'b1;
        pend_d      = 1'b0;
      end else begin
        if (deq_req)   pend_d      = 1'b1;
        if (out_ready) out_valid_d = 1'b0;
      end
      if (pq_enq) begin
        kvi_hold_d = gnt_kv;
        rr_ptr_d   = (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      out_kv_q    <= '0;
      pend_q      <= 1'b0;
      rr_ptr_q    <= '0;
      kvi_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_kv_q    <= out_kv_d;
      pend_q      <= pend_d;
      rr_ptr_q    <= rr_ptr_d;
      kvi_hold_q  <= kvi_hold_d;
    end
  end

`ifdef PQ_SHARE_STATS_EN
  logic [31:0] enq_cnt_q, deq_cnt_q, stall_cnt_q;
  logic        stall;

  assign stall          = run && (|req_valid) && !enq_ok;
  assign stat_enq_cnt   = enq_cnt_q;
  assign stat_deq_cnt   = deq_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || flush || (state_q == ST_FLUSH)) begin
      enq_cnt_q   <= '0;
      deq_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pq_enq && (enq_cnt_q != '1))   enq_cnt_q   <= enq_cnt_q + 32'd1;
      if (pq_deq && (deq_cnt_q != '1))   deq_cnt_q   <= deq_cnt_q + 32'd1;
      if (stall && (stall_cnt_q != '1))  stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pq_share_ctrl.sv
// tb/tb_pq_share_ctrl.sv - directed-vector bench for pq_share_ctrl; the PQ side is driven by hand
module tb_pq_share_ctrl;
  localparam int NREQ = 4;
  localparam int KW   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*KW-1:0] req_kv;
  logic [NREQ-1:0]   req_ready;
  logic              deq_req, out_valid, out_ready, flush, busy;
  logic [KW-1:0]     out_kv, pq_kvi, pq_kvo;
  logic              pq_rst, pq_enq, pq_deq, pq_empty, pq_full;

  int n_vec = 0;
  int n_bad = 0;

  pq_share_ctrl #(.NREQ(NREQ), .KEY_WIDTH(8), .VAL_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_kv(req_kv), .req_ready(req_ready),
    .deq_req(deq_req), .out_valid(out_valid), .out_kv(out_kv), .out_ready(out_ready),
    .flush(flush), .busy(busy), .pq_rst(pq_rst), .pq_enq(pq_enq), .pq_deq(pq_deq),
    .pq_kvi(pq_kvi), .pq_kvo(pq_kvo), .pq_empty(pq_empty), .pq_full(pq_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'hF; deq_req = 0; out_ready = 0; flush = 0;
    pq_kvo = '0; pq_empty = 1; pq_full = 0;
    req_kv = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
    tick(); tick();
    #2;
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_pq_enq", 32'(pq_enq), 32'h0);
    check("rst_pq_rst", 32'(pq_rst), 32'h1);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_busy_kvi", {15'd0, busy, pq_kvi}, 32'h0);
    rst = 1'b0; req_valid = '0;
    #2;
    check("run_pq_rst", 32'(pq_rst), 32'h0);

    // round robin: clients 0 and 2 together from rr_ptr=0
    tick();
    req_kv = '0;
    req_kv[0*KW +: KW] = 16'h080E;
    req_kv[2*KW +: KW] = 16'h020C;
    req_valid = 4'b0101;
    #2;
    check("rr_t0_ready", 32'(req_ready), 32'h1);
    check("rr_t0_kvi", {15'd0, pq_enq, pq_kvi}, 32'h1080E);
    tick();
    req_valid = 4'b0100;
    #2;
    check("rr_t1_ready", 32'(req_ready), 32'h4);
    check("rr_t1_kvi", 32'(pq_kvi), 32'h020C);
    tick();
    req_valid = '0;
    #2;
    check("kvi_hold", {15'd0, pq_enq, pq_kvi}, 32'h020C);
    req_valid = 4'hF;
    #1;
    check("rr_ptr3_grant", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;

    // pop with consumer stalled, then a second pop waiting for the slot
    pq_empty = 0; pq_kvo = 16'h020C; deq_req = 1;
    #2;
    check("pop1_deq", 32'(pq_deq), 32'h1);
    tick();
    deq_req = 0; pq_kvo = 16'h080E;
    check("pop1_out", {15'd0, out_valid, out_kv}, 32'h1020C);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pop1_hold", {15'd0, out_valid, out_kv}, 32'h1020C);
    end
    deq_req = 1;
    #2;
    check("pop2_blocked", 32'(pq_deq), 32'h0);
    tick();
    deq_req = 0;
    #2;
    check("pop2_pending", {30'd0, busy, pq_deq}, 32'h2);
    out_ready = 1;
    #1;
    check("pop2_release", 32'(pq_deq), 32'h1);
    tick();
    out_ready = 0; pq_empty = 1;
    check("pop2_out", {15'd0, out_valid, out_kv}, 32'h1080E);
    check("pop2_busy", 32'(busy), 32'h0);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("slot_drained", 32'(out_valid), 32'h0);

    // full queue: no grant without a pop, simultaneous enq+deq with a pop
    pq_full = 1; pq_empty = 0; pq_kvo = 16'h020C;
    req_kv[1*KW +: KW] = 16'h090A; req_valid = 4'b0010;
    #2;
    check("full_block", {27'd0, pq_enq, req_ready}, 32'h0);
    deq_req = 1;
    #1;
    check("full_enq_deq", {26'd0, pq_enq, pq_deq, req_ready}, 32'h32);
    check("full_kvi", 32'(pq_kvi), 32'h090A);
    tick();
    deq_req = 0; req_valid = '0; pq_full = 0;
    out_ready = 1;
    tick();
    out_ready = 0;

    // empty queue: pop waits a cycle for an entry enqueued alongside the request
    pq_empty = 1; deq_req = 1;
    req_kv[3*KW +: KW] = 16'h010B; req_valid = 4'b1000;
    #2;
    check("emp_t0", {26'd0, pq_enq, pq_deq, req_ready}, 32'h28);
    tick();
    deq_req = 0; req_valid = '0; pq_empty = 0; pq_kvo = 16'h010B;
    check("emp_t1_pend", 32'(busy), 32'h1);
    #2;
    check("emp_t1_deq", 32'(pq_deq), 32'h1);
    tick();
    pq_empty = 1;
    check("emp_t2_out", {15'd0, out_valid, out_kv}, 32'h1010B);
    check("emp_t2_busy", 32'(busy), 32'h0);

    // flush with a full slot and a pending pop
    deq_req = 1;
    tick();
    deq_req = 0; flush = 1;
    check("fl_pre_busy", {30'd0, busy, out_valid}, 32'h3);
    tick();
    flush = 0; req_valid = 4'b0001; req_kv[0*KW +: KW] = 16'h0505;
    #2;
    check("fl_t1", {28'd0, pq_rst, pq_enq, busy, 1'b0}, 32'hA);
    check("fl_t1_ready", 32'(req_ready), 32'h0);
    tick();
    #1;
    check("fl_t2", {29'd0, out_valid, busy, pq_rst}, 32'h0);
    check("fl_t2_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
